// File: rtl/hazard_ctrl_md_pkg.sv
// Shared encodings and helpers for the pipeline hazard unit with MD busy tracking.
package hazard_ctrl_md_pkg;

  localparam int unsigned TW = 2;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FWD_GRF = 2'd0,
    FWD_W   = 2'd1,
    FWD_M   = 2'd2,
    FWD_E   = 2'd3
  } fwd_sel_e;

  // $0 is never a real producer, so a write to it must not match any reader.
  function automatic logic reg_match(input logic we, input logic [4:0] wa, input logic [4:0] ra);
    return we && (wa != REG_ZERO) && (wa == ra);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_tracker.sv
// Multiply/divide busy counter: loads the op latency on a start, counts down, flags completion.
module hazard_ctrl_md_busy_tracker
  import hazard_ctrl_md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_md_start,
  input  logic i_md_is_div,
  output logic o_md_busy,
  output logic o_md_done
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_done;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_md_start && (r_cnt == '0)) begin
      w_cnt_nxt = i_md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_done <= (r_cnt == CNT_W'(1));
    end
  end

  assign o_md_busy = i_md_start | (r_cnt != '0);
  assign o_md_done = r_done;

  // A start while busy is ignored by the counter; the D-stage stall should make it impossible.
  a_no_start_while_busy : assert property (
    @(posedge i_clk) disable iff (i_reset) !(i_md_start && (r_cnt != '0))
  );

endmodule

// File: rtl/hazard_ctrl_md.sv
// Pipeline hazard unit: Tuse/Tnew stall detection, forwarding selects, MD busy and stall counter.
module hazard_ctrl_md
  import hazard_ctrl_md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned PERF_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_use_rs_D,
  input  logic              i_use_rt_D,
  input  logic [4:0]        i_rs_D,
  input  logic [4:0]        i_rt_D,
  input  logic [TW-1:0]     i_tuse_rs_D,
  input  logic [TW-1:0]     i_tuse_rt_D,
  input  logic              i_md_op_D,
  input  logic              i_we_E,
  input  logic [4:0]        i_wa_E,
  input  logic [TW-1:0]     i_tnew_E,
  input  logic              i_we_M,
  input  logic [4:0]        i_wa_M,
  input  logic [TW-1:0]     i_tnew_M,
  input  logic              i_we_W,
  input  logic [4:0]        i_wa_W,
  input  logic [4:0]        i_rs_E,
  input  logic [4:0]        i_rt_E,
  input  logic [4:0]        i_rt_M,
  input  logic              i_md_start_E,
  input  logic              i_md_is_div_E,
  input  logic              i_perf_clr,
  output logic              o_stall,
  output logic [1:0]        o_fwd_rs_D,
  output logic [1:0]        o_fwd_rt_D,
  output logic [1:0]        o_fwd_rs_E,
  output logic [1:0]        o_fwd_rt_E,
  output logic              o_fwd_rt_M,
  output logic              o_md_busy,
  output logic              o_md_done,
  output logic [PERF_W-1:0] o_stall_cnt
);

  logic              w_md_busy;
  logic              w_stall_rs;
  logic              w_stall_rt;
  logic              w_stall;
  fwd_sel_e          w_fwd_rs_D;
  fwd_sel_e          w_fwd_rt_D;
  fwd_sel_e          w_fwd_rs_E;
  fwd_sel_e          w_fwd_rt_E;
  logic [PERF_W-1:0] r_stall_cnt;

  hazard_ctrl_md_busy_tracker #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_busy_tracker (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_md_start (i_md_start_E),
    .i_md_is_div(i_md_is_div_E),
    .o_md_busy  (w_md_busy),
    .o_md_done  (o_md_done)
  );

  // A value is late when the reader needs it (Tuse) before the producer has it (Tnew).
  always_comb begin
    w_stall_rs = i_use_rs_D &&
                 ((reg_match(i_we_E, i_wa_E, i_rs_D) && (i_tuse_rs_D < i_tnew_E)) ||
                  (reg_match(i_we_M, i_wa_M, i_rs_D) && (i_tuse_rs_D < i_tnew_M)));
    w_stall_rt = i_use_rt_D &&
                 ((reg_match(i_we_E, i_wa_E, i_rt_D) && (i_tuse_rt_D < i_tnew_E)) ||
                  (reg_match(i_we_M, i_wa_M, i_rt_D) && (i_tuse_rt_D < i_tnew_M)));
    w_stall    = w_stall_rs | w_stall_rt | (i_md_op_D & w_md_busy);
  end

  // Youngest matching producer wins; if its value is not ready yet, fall back to the GRF.
  always_comb begin
    w_fwd_rs_D = FWD_GRF;
    if (reg_match(i_we_E, i_wa_E, i_rs_D))      w_fwd_rs_D = (i_tnew_E == '0) ? FWD_E : FWD_GRF;
    else if (reg_match(i_we_M, i_wa_M, i_rs_D)) w_fwd_rs_D = (i_tnew_M == '0) ? FWD_M : FWD_GRF;
    else if (reg_match(i_we_W, i_wa_W, i_rs_D)) w_fwd_rs_D = FWD_W;

    w_fwd_rt_D = FWD_GRF;
    if (reg_match(i_we_E, i_wa_E, i_rt_D))      w_fwd_rt_D = (i_tnew_E == '0) ? FWD_E : FWD_GRF;
    else if (reg_match(i_we_M, i_wa_M, i_rt_D)) w_fwd_rt_D = (i_tnew_M == '0) ? FWD_M : FWD_GRF;
    else if (reg_match(i_we_W, i_wa_W, i_rt_D)) w_fwd_rt_D = FWD_W;

    w_fwd_rs_E = FWD_GRF;
    if (reg_match(i_we_M, i_wa_M, i_rs_E))      w_fwd_rs_E = (i_tnew_M == '0) ? FWD_M : FWD_GRF;
    else if (reg_match(i_we_W, i_wa_W, i_rs_E)) w_fwd_rs_E = FWD_W;

    w_fwd_rt_E = FWD_GRF;
    if (reg_match(i_we_M, i_wa_M, i_rt_E))      w_fwd_rt_E = (i_tnew_M == '0) ? FWD_M : FWD_GRF;
    else if (reg_match(i_we_W, i_wa_W, i_rt_E)) w_fwd_rt_E = FWD_W;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
    end else if (i_perf_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + PERF_W'(1);
    end
  end

  assign o_stall     = w_stall;
  assign o_fwd_rs_D  = w_fwd_rs_D;
  assign o_fwd_rt_D  = w_fwd_rt_D;
  assign o_fwd_rs_E  = w_fwd_rs_E;
  assign o_fwd_rt_E  = w_fwd_rt_E;
  assign o_fwd_rt_M  = reg_match(i_we_W, i_wa_W, i_rt_M);
  assign o_md_busy   = w_md_busy;
  assign o_stall_cnt = r_stall_cnt;

endmodule
